mem_access_stage: RTL and testbench

- Consumer side of the EXE/MEM pipeline register. Takes the registered mem_* controls and data and performs the data-memory access over a req/ack handshake.
- Stalls upstream stages while a memory access is outstanding.
- Drives the MEM/WB register: writeback enable, destination and data to the register file.
- Sits between the EXE/MEM register and the register-file write port.

---
 rtl/mem_pkg.sv | 14 +
 rtl/wb_src_mux.sv | 27 ++
 rtl/mem_access_stage.sv | 121 ++++++++++++
 tb/tb_mem_access_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_pkg;

  // Default widths; these match the core's register and instruction-address buses.
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 32;

  typedef enum logic {IDLE, ACCESS} mem_state_t;

  // Writeback source selects.
  localparam logic LW_SRC_DM  = 1'b1;
  localparam logic MV_SRC_MOV = 1'b1;

endpackage

// File: rtl/wb_src_mux.sv
// Writeback data selection: load data, move-path result or ALU result.
module wb_src_mux
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              use_load,
  input  logic              lwsrc,
  input  logic              movsrc,
  input  logic [DATA_W-1:0] load_data,
  input  logic [DATA_W-1:0] move_data,
  input  logic [DATA_W-1:0] alu_data,
  output logic [DATA_W-1:0] wb_data
);

  // Load data is only meaningful when a memory access is completing.
  always_comb begin
    if (use_load && (lwsrc == LW_SRC_DM)) begin
      wb_data = load_data;
    end else if (movsrc == MV_SRC_MOV) begin
      wb_data = move_data;
    end else begin
      wb_data = alu_data;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory req/ack access, upstream stall and MEM/WB register.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_sw_o,
  input  logic [DATA_W-1:0] mem_write_o,
  input  logic              mem_lwsrc,
  input  logic              mem_movsrc,
  input  logic [ADDR_W-1:0] mem_write_addr_o,
  input  logic              mem_reg_write,
  input  logic              mem_DM_read,
  input  logic              mem_DM_write,
  input  logic [DATA_W-1:0] mem_alu_result,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic              stall_o,
  output logic              dm_err_o,
  output logic              wb_reg_write,
  output logic [ADDR_W-1:0] wb_write_addr,
  output logic [DATA_W-1:0] wb_data
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  mem_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              mem_op;
  logic              timeout_hit;
  logic [DATA_W-1:0] wb_sel;

  wb_src_mux #(
    .DATA_W (DATA_W)
  ) u_wb_src_mux (
    .use_load  (state == ACCESS),
    .lwsrc     (mem_lwsrc),
    .movsrc    (mem_movsrc),
    .load_data (dm_rdata),
    .move_data (mem_write_o),
    .alu_data  (mem_alu_result),
    .wb_data   (wb_sel)
  );

  // Op detection, timeout detection and the upstream stall.
  always_comb begin
    mem_op      = mem_DM_read | mem_DM_write;
    timeout_hit = (state == ACCESS) && !dm_ack && (cnt == CNT_W'(TIMEOUT - 1));
    stall_o     = 1'b0;
    case (state)
      IDLE:    stall_o = mem_op;
      // The abort cycle also releases the stall so the dead op drains out.
      ACCESS:  stall_o = !(dm_ack || timeout_hit);
      default: stall_o = 1'b0;
    endcase
  end

  // Access FSM, timeout counter, memory request and MEM/WB registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      dm_req        <= 1'b0;
      dm_we         <= 1'b0;
      dm_addr       <= '0;
      dm_wdata      <= '0;
      dm_err_o      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_write_addr <= '0;
      wb_data       <= '0;
    end else begin
      dm_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            state        <= ACCESS;
            cnt          <= '0;
            dm_req       <= 1'b1;
            dm_addr      <= mem_alu_result;
            dm_wdata     <= mem_sw_o;
            // Read+write together resolves to a store and is flagged.
            dm_we        <= mem_DM_write;
            dm_err_o     <= mem_DM_read & mem_DM_write;
            wb_reg_write <= 1'b0;
          end else begin
            wb_reg_write  <= mem_reg_write;
            wb_write_addr <= mem_write_addr_o;
            wb_data       <= wb_sel;
          end
        end
        ACCESS: begin
          if (dm_ack) begin
            state         <= IDLE;
            dm_req        <= 1'b0;
            wb_reg_write  <= mem_reg_write;
            wb_write_addr <= mem_write_addr_o;
            wb_data       <= wb_sel;
          end else if (timeout_hit) begin
            state        <= IDLE;
            dm_req       <= 1'b0;
            dm_err_o     <= 1'b1;
            wb_reg_write <= 1'b0;
          end else begin
            cnt          <= cnt + 1'b1;
            wb_reg_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed scoreboard bench for mem_access_stage.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_sw_o, mem_write_o, mem_write_addr_o, mem_alu_result, dm_rdata;
  logic        mem_lwsrc, mem_movsrc, mem_reg_write, mem_DM_read, mem_DM_write, dm_ack;
  logic        dm_req, dm_we, stall_o, dm_err_o, wb_reg_write;
  logic [31:0] dm_addr, dm_wdata, wb_write_addr, wb_data;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  mem_access_stage #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .TIMEOUT (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_sw_o         (mem_sw_o),
    .mem_write_o      (mem_write_o),
    .mem_lwsrc        (mem_lwsrc),
    .mem_movsrc       (mem_movsrc),
    .mem_write_addr_o (mem_write_addr_o),
    .mem_reg_write    (mem_reg_write),
    .mem_DM_read      (mem_DM_read),
    .mem_DM_write     (mem_DM_write),
    .mem_alu_result   (mem_alu_result),
    .dm_req           (dm_req),
    .dm_we            (dm_we),
    .dm_addr          (dm_addr),
    .dm_wdata         (dm_wdata),
    .dm_rdata         (dm_rdata),
    .dm_ack           (dm_ack),
    .stall_o          (stall_o),
    .dm_err_o         (dm_err_o),
    .wb_reg_write     (wb_reg_write),
    .wb_write_addr    (wb_write_addr),
    .wb_data          (wb_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] alu,
                       input logic [31:0] sw, input logic [31:0] mv_val, input logic rw,
                       input logic [31:0] dst, input logic lw, input logic mv);
    mem_DM_read      = rd;
    mem_DM_write     = wr;
    mem_alu_result   = alu;
    mem_sw_o         = sw;
    mem_write_o      = mv_val;
    mem_reg_write    = rw;
    mem_write_addr_o = dst;
    mem_lwsrc        = lw;
    mem_movsrc       = mv;
  endtask

  task automatic set_idle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    dm_ack   = 1'b0;
    dm_rdata = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expected writeback and compare against the WB register.
  task automatic sb_check(input string tag);
    wb_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_wb_rw"}, wb_reg_write, e.rw);
      if (e.rw) begin
        chk({tag, "_wb_addr"}, wb_write_addr, e.addr);
        chk({tag, "_wb_data"}, wb_data, e.data);
      end
    end
  endtask

  // Non-memory op: one-cycle pass-through, never stalls.
  task automatic alu_op(input string tag, input logic [31:0] alu, input logic [31:0] mv_val,
                        input logic rw, input logic [31:0] dst, input logic lw, input logic mv,
                        input logic [31:0] exp_data, input logic ack);
    cyc();
    drive(1'b0, 1'b0, alu, 32'h0, mv_val, rw, dst, lw, mv);
    dm_ack = ack;
    exp_q.push_back('{rw: rw, addr: dst, data: exp_data});
    @(negedge clk);
    chk({tag, "_stall"}, stall_o, 1'b0);
    cyc();
    set_idle();
    @(negedge clk);
    chk({tag, "_req"}, dm_req, 1'b0);
    sb_check(tag);
  endtask

  // Memory op; ack_at is the ACCESS cycle index carrying the ack (-1 = never).
  task automatic mem_op(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] mv_val, input logic rw,
                        input logic [31:0] dst, input logic lw, input logic mv, input int ack_at,
                        input logic [31:0] rdata, input wb_t exp_wb, input int exp_stall,
                        input int exp_err, input logic exp_we);
    int   stalls;
    int   reqs;
    int   errs;
    logic released;
    stalls   = 0;
    reqs     = 0;
    errs     = 0;
    released = 1'b0;
    cyc();
    drive(rd, wr, addr, wdata, mv_val, rw, dst, lw, mv);
    exp_q.push_back(exp_wb);
    @(negedge clk);
    chk({tag, "_op_stall"}, stall_o, 1'b1);
    chk({tag, "_op_req"}, dm_req, 1'b0);
    if (stall_o) stalls++;
    for (int k = 0; k < 40; k++) begin
      cyc();
      dm_ack   = (k == ack_at);
      dm_rdata = (k == ack_at) ? rdata : 32'h0;
      @(negedge clk);
      if (dm_req) reqs++;
      if (dm_err_o) errs++;
      if (k == 0) begin
        chk({tag, "_req_addr"}, dm_addr, addr);
        chk({tag, "_req_we"}, dm_we, exp_we);
        if (exp_we) chk({tag, "_req_wdata"}, dm_wdata, wdata);
        chk({tag, "_bubble"}, wb_reg_write, 1'b0);
      end
      if (stall_o) begin
        stalls++;
      end else begin
        released = 1'b1;
        break;
      end
    end
    chk({tag, "_released"}, released, 1'b1);
    cyc();
    set_idle();
    @(negedge clk);
    if (dm_err_o) errs++;
    chk({tag, "_req_drop"}, dm_req, 1'b0);
    chk({tag, "_stall_cycles"}, stalls, exp_stall);
    chk({tag, "_req_cycles"}, reqs, exp_stall);
    chk({tag, "_err_pulses"}, errs, exp_err);
    sb_check(tag);
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_req", dm_req, 1'b0);
    chk("rst_we", dm_we, 1'b0);
    chk("rst_err", dm_err_o, 1'b0);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_wb_rw", wb_reg_write, 1'b0);
    chk("rst_wb_addr", wb_write_addr, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_dm_wdata", dm_wdata, 32'h0);
    cyc();
    rst = 1'b0;

    // Pass-through: ALU, move path, lwsrc ignored without a memory op, ack in IDLE ignored.
    alu_op("alu", 32'h0000_1234, 32'h0, 1'b1, 32'd5, 1'b0, 1'b0, 32'h0000_1234, 1'b0);
    alu_op("mov", 32'h0000_0001, 32'h0000_CAFE, 1'b1, 32'd6, 1'b0, 1'b1, 32'h0000_CAFE, 1'b0);
    alu_op("lw_noop", 32'h0000_0777, 32'h0, 1'b1, 32'd3, 1'b1, 1'b0, 32'h0000_0777, 1'b1);

    // Load, ack on the third ACCESS cycle: three stall cycles.
    mem_op("load", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 32'd7, 1'b1, 1'b0, 2,
           32'hDEAD_BEEF, '{rw: 1'b1, addr: 32'd7, data: 32'hDEAD_BEEF}, 3, 0, 1'b0);

    // Store with immediate ack, no writeback.
    mem_op("store", 1'b0, 1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 32'h0, 1'b0, 32'd2, 1'b0, 1'b0, 0,
           32'h0, '{rw: 1'b0, addr: 32'd0, data: 32'd0}, 1, 0, 1'b1);

    // Load that never gets an ack: 16 ACCESS cycles then abort with one error pulse.
    mem_op("timeout", 1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h0, 1'b1, 32'd8, 1'b1, 1'b0, -1,
           32'h0, '{rw: 1'b0, addr: 32'd0, data: 32'd0}, 16, 1, 1'b0);

    // Read+write together: store, error pulse, writeback of the move value.
    mem_op("rdwr", 1'b1, 1'b1, 32'h0000_0400, 32'h1357_9BDF, 32'h0000_5555, 1'b1, 32'd9, 1'b0,
           1'b1, 1, 32'hFFFF_FFFF, '{rw: 1'b1, addr: 32'd9, data: 32'h0000_5555}, 2, 1, 1'b1);

    // Reset on the second ACCESS cycle, then a late ack.
    cyc();
    drive(1'b1, 1'b0, 32'h0000_0500, 32'h0, 32'h0, 1'b1, 32'd11, 1'b1, 1'b0);
    cyc();
    @(negedge clk);
    chk("rstmid_req_on", dm_req, 1'b1);
    cyc();
    rst = 1'b1;
    set_idle();
    cyc();
    rst      = 1'b0;
    dm_ack   = 1'b1;
    dm_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("rstmid_req", dm_req, 1'b0);
    chk("rstmid_stall", stall_o, 1'b0);
    chk("rstmid_wb_rw", wb_reg_write, 1'b0);
    chk("rstmid_wb_data", wb_data, 32'h0);
    chk("rstmid_dm_addr", dm_addr, 32'h0);
    cyc();
    set_idle();
    @(negedge clk);
    chk("rstmid_late_ack_req", dm_req, 1'b0);
    chk("rstmid_late_ack_wb", wb_reg_write, 1'b0);
    chk("rstmid_late_ack_data", wb_data, 32'h0);
    chk("rstmid_late_ack_err", dm_err_o, 1'b0);

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
